// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch bus bundle (imem req/ack, decode valid/ready, npc feedback, fault report)
// master = fetch unit side, slave = memory/decode/NPC side.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] npc_in;
  logic        fault;
  logic [31:0] fault_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out, fault, fault_pc,
    input  imem_ack, imem_rdata, instr_ready, npc_in
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out, fault, fault_pc,
    output imem_ack, imem_rdata, instr_ready, npc_in
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: MIPS fetch front end; owns PC, fetches over req/ack, hands instr to decode over valid/ready
// Ports: clk, reset_n (async active-low), bus (ifu_fetch_if.master: imem_*, instr_*, pc_out, npc_in, fault, fault_pc).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input logic         clk,
  input logic         reset_n,
  ifu_fetch_if.master bus
);
  typedef enum logic [1:0] {REQ, VALID, FAULT} state_t;
  // 33-bit end address so a range reaching the top of the address space does not wrap
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + {IMEM_WORDS[30:0], 2'b00};
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, fault_pc_q, fault_pc_d;
  logic        fault_q, fault_d, legal;
  assign legal = bus.npc_in[1:0] == 2'b00 && bus.npc_in >= IMEM_BASE && {1'b0, bus.npc_in} < IMEM_END;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      REQ: if (bus.imem_ack) begin
        instr_d = bus.imem_rdata;
        state_d = VALID;
      end
      VALID: if (bus.instr_ready) begin
        pc_d       = legal ? bus.npc_in : pc_q;
        fault_d    = !legal;
        fault_pc_d = legal ? fault_pc_q : bus.npc_in;
        state_d    = legal ? REQ : FAULT;
      end
      FAULT: state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  // state sits at REQ during reset, so the request is gated off by reset_n directly
  assign bus.imem_req    = reset_n && state_q == REQ;
  assign bus.imem_addr   = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = state_q == VALID;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: random + directed bench for ifu_fetch against a transaction-level model
module tb_ifu_fetch;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int WORDS = 4096;
  logic clk = 0, reset_n = 0, ack = 0, ready = 0, npc_auto = 0;
  logic [31:0] rdata = 0, npc_val = 0;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_instr, m_fpc;
  logic m_hold, m_dead;
  ifu_fetch_if bus();
  assign bus.imem_ack    = ack;
  assign bus.imem_rdata  = rdata;
  assign bus.instr_ready = ready;
  assign bus.npc_in      = npc_auto ? bus.pc_out + 32'd4 : npc_val;
  ifu_fetch dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic bit legal(input logic [31:0] a);
    longint unsigned x = 64'(a);
    return (x % 4 == 0) && x >= 64'(BASE) && (x - 64'(BASE)) < 64'(4 * WORDS);
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_pc <= BASE; m_instr <= 0; m_fpc <= 0; m_hold <= 0; m_dead <= 0;
    end else if (!m_dead) begin
      if (!m_hold) begin
        if (ack) begin m_instr <= rdata; m_hold <= 1; end
      end else if (ready) begin
        m_hold <= 0;
        if (legal(bus.npc_in)) m_pc <= bus.npc_in;
        else begin m_dead <= 1; m_fpc <= bus.npc_in; end
      end
    end
  always @(negedge clk) begin
    chk("imem_req", 32'(bus.imem_req), 32'(reset_n && !m_hold && !m_dead));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc_out", bus.pc_out, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_hold && !m_dead));
    if (m_hold) chk("instr", bus.instr, m_instr);
    chk("fault", 32'(bus.fault), 32'(m_dead));
    chk("fault_pc", bus.fault_pc, m_fpc);
  end
  task automatic step();
    @(negedge clk); #1;
  endtask
  task automatic restart();
    reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
  endtask
  task automatic to_3004();
    ack = 1; ready = 1; npc_auto = 1; rdata = 32'h0000_0020;
    restart();
    step(); step(); step();
    ready = 0; npc_auto = 0;
    step();
    ack = 0;
    chk("at3004_valid", 32'(bus.instr_valid), 1);
    chk("at3004_pc", bus.pc_out, 32'h3004);
  endtask
  initial begin
    repeat (2) step();
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_fault_pc", bus.fault_pc, 0);
    chk("rst_pc", bus.pc_out, 32'h3000);
    chk("rst_instr", bus.instr, 0);
    ack = 1; rdata = 32'h2408_0001; ready = 1; npc_auto = 1;
    @(posedge clk); #1 reset_n = 1;
    step(); chk("zl_req0", 32'(bus.imem_req), 1); chk("zl_addr0", bus.imem_addr, 32'h3000);
    step(); chk("zl_valid0", 32'(bus.instr_valid), 1); chk("zl_instr0", bus.instr, 32'h2408_0001);
    chk("zl_req_off", 32'(bus.imem_req), 0);
    step(); chk("zl_addr1", bus.imem_addr, 32'h3004); chk("zl_valid_off", 32'(bus.instr_valid), 0);
    step(); chk("zl_valid1", 32'(bus.instr_valid), 1);
    step(); chk("zl_addr2", bus.imem_addr, 32'h3008);
    ack = 0; ready = 0;
    restart();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lat_req", 32'(bus.imem_req), 1);
      chk("lat_addr", bus.imem_addr, 32'h3000);
      chk("lat_valid", 32'(bus.instr_valid), 0);
    end
    rdata = 32'h8C09_0004; ack = 1;
    step(); ack = 0;
    chk("lat_valid_on", 32'(bus.instr_valid), 1);
    chk("lat_instr", bus.instr, 32'h8C09_0004);
    npc_auto = 0;
    for (int i = 0; i < 5; i++) begin
      npc_val = (i % 2 == 1) ? 32'h3020 : 32'h3010;
      step();
      chk("hold_valid", 32'(bus.instr_valid), 1);
      chk("hold_pc", bus.pc_out, 32'h3000);
      chk("hold_instr", bus.instr, 32'h8C09_0004);
    end
    npc_val = 32'h3020; ready = 1;
    step(); ready = 0;
    chk("hold_next_addr", bus.imem_addr, 32'h3020);
    to_3004();
    npc_val = 32'h3100; ready = 1;
    step(); ready = 0;
    chk("br_addr", bus.imem_addr, 32'h3100);
    chk("br_req", 32'(bus.imem_req), 1);
    to_3004();
    npc_val = 32'h3006; ready = 1;
    step();
    chk("mis_fault", 32'(bus.fault), 1);
    chk("mis_fault_pc", bus.fault_pc, 32'h3006);
    for (int i = 0; i < 5; i++) begin
      ack = 1'($urandom); ready = 1'($urandom); npc_val = BASE;
      step();
      chk("dead_req", 32'(bus.imem_req), 0);
      chk("dead_valid", 32'(bus.instr_valid), 0);
      chk("dead_pc", bus.pc_out, 32'h3004);
      chk("dead_fault", 32'(bus.fault), 1);
    end
    #1 reset_n = 0;
    #1 chk("frst_fault", 32'(bus.fault), 0);
    chk("frst_fault_pc", bus.fault_pc, 0);
    chk("frst_req", 32'(bus.imem_req), 0);
    to_3004();
    npc_val = 32'h7000; ready = 1;
    step(); ready = 0;
    chk("oor_fault", 32'(bus.fault), 1);
    chk("oor_fault_pc", bus.fault_pc, 32'h7000);
    to_3004();
    npc_val = 32'h6FFC; ready = 1;
    step(); ready = 0;
    chk("top_fault", 32'(bus.fault), 0);
    chk("top_addr", bus.imem_addr, 32'h6FFC);
    ack = 0;
    restart();
    step(); step();
    chk("ar_req_pre", 32'(bus.imem_req), 1);
    #2 reset_n = 0; ack = 1;
    #1 chk("ar_req", 32'(bus.imem_req), 0);
    chk("ar_fault", 32'(bus.fault), 0);
    @(posedge clk); @(posedge clk); #1 ack = 0; reset_n = 1;
    step();
    chk("ar_restart_addr", bus.imem_addr, 32'h3000);
    chk("ar_restart_valid", 32'(bus.instr_valid), 0);
    step();
    chk("ar_no_ack", 32'(bus.instr_valid), 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      step();
      ack = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      ready = 1'($urandom);
      r = $urandom_range(0, 19);
      npc_val = r < 12 ? m_pc + 32'd4 :
                r < 16 ? BASE + 32'(4 * $urandom_range(0, WORDS - 1)) :
                r == 16 ? BASE + 32'(4 * WORDS - 4) :
                r == 17 ? BASE + 32'(4 * WORDS) :
                r == 18 ? (($urandom_range(0, 1) == 1) ? BASE - 32'd4 : 32'hFFFF_FFFC) :
                m_pc + 32'($urandom_range(1, 3));
      if (m_dead ? $urandom_range(0, 5) == 0 : $urandom_range(0, 300) == 0) begin
        reset_n = 0;
        #2 reset_n = 1;
      end
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
